// File: rtl/divider_if.sv
// divider_if: start/finished handshake plus operand and result buses for the divider.
interface divider_if #(parameter int BITS = 8);
   logic            i_start;
   logic            o_busy;
   logic            o_finished;
   logic [BITS-1:0] i_dividend;
   logic [BITS-1:0] i_divisor;
   logic [BITS-1:0] o_quotient;
   logic [BITS-1:0] o_remainder;
   logic            o_div_by_zero;
   modport master (output i_start, i_dividend, i_divisor,
                   input  o_busy, o_finished, o_quotient, o_remainder, o_div_by_zero);
   modport slave  (input  i_start, i_dividend, i_divisor,
                   output o_busy, o_finished, o_quotient, o_remainder, o_div_by_zero);
endinterface

// File: rtl/divider.sv
// divider: sequential restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncation toward zero).
module divider #(parameter int BITS = 8) (
   input logic i_clock,
   input logic i_reset,
   divider_if.slave bus
);
   localparam int CW = $clog2(BITS);
   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BITS-1:0] q_q, q_d, d_q, d_d, r_q, r_d;
   logic [BITS-1:0] quo_q, quo_d, rem_q, rem_d;
   logic            dz_q, dz_d, dzo_q, dzo_d;
   logic [BITS:0]   r_shift;
   logic [BITS+1:0] diff;
   logic [BITS-1:0] q_next, r_next, quo_res, rem_res, dvd_in, dvs_in;
   logic            ge, load, iter, last;
`ifdef DIVIDER_SIGNED_EN
   logic            nq_q, nq_d, nr_q, nr_d;
   logic [BITS-1:0] raw_q, raw_d;
`endif
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      last    = cnt_q == CW'(BITS-1);
      state_d = (state_q == IDLE) ? (bus.i_start ? ITER : IDLE) :
                (state_q == ITER) ? (last ? DONE : ITER) : IDLE;
   end
   always_comb begin
      bus.o_busy        = state_q != IDLE;
      bus.o_finished    = state_q == DONE;
      bus.o_quotient    = quo_q;
      bus.o_remainder   = rem_q;
      bus.o_div_by_zero = dzo_q;
   end
   always_comb begin
      load    = state_q == IDLE && bus.i_start;
      iter    = state_q == ITER;
      r_shift = {r_q, q_q[BITS-1]};
      diff    = {1'b0, r_shift} - {2'b0, d_q};
      ge      = !diff[BITS+1];
      q_next  = {q_q[BITS-2:0], ge};
      r_next  = ge ? diff[BITS-1:0] : r_shift[BITS-1:0];
`ifdef DIVIDER_SIGNED_EN
      dvd_in  = bus.i_dividend[BITS-1] ? -bus.i_dividend : bus.i_dividend;
      dvs_in  = bus.i_divisor[BITS-1] ? -bus.i_divisor : bus.i_divisor;
      nq_d    = load ? bus.i_dividend[BITS-1] ^ bus.i_divisor[BITS-1] : nq_q;
      nr_d    = load ? bus.i_dividend[BITS-1] : nr_q;
      raw_d   = load ? bus.i_dividend : raw_q;
      // a zero divisor keeps the raw dividend rather than its magnitude
      quo_res = dz_q ? '1 : (nq_q ? -q_next : q_next);
      rem_res = dz_q ? raw_q : (nr_q ? -r_next : r_next);
`else
      dvd_in  = bus.i_dividend;
      dvs_in  = bus.i_divisor;
      quo_res = q_next;
      rem_res = r_next;
`endif
      q_d     = load ? dvd_in : iter ? q_next : q_q;
      d_d     = load ? dvs_in : d_q;
      r_d     = load ? '0 : iter ? r_next : r_q;
      cnt_d   = load ? '0 : iter ? cnt_q + 1'b1 : cnt_q;
      dz_d    = load ? bus.i_divisor == '0 : dz_q;
      quo_d   = iter && last ? quo_res : quo_q;
      rem_d   = iter && last ? rem_res : rem_q;
      dzo_d   = iter && last ? dz_q : dzo_q;
   end
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) begin
         cnt_q <= '0;
         q_q   <= '0;
         d_q   <= '0;
         r_q   <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dz_q  <= 1'b0;
         dzo_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         nq_q  <= 1'b0;
         nr_q  <= 1'b0;
         raw_q <= '0;
`endif
      end else begin
         cnt_q <= cnt_d;
         q_q   <= q_d;
         d_q   <= d_d;
         r_q   <= r_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dz_q  <= dz_d;
         dzo_q <= dzo_d;
`ifdef DIVIDER_SIGNED_EN
         nq_q  <= nq_d;
         nr_q  <= nr_d;
         raw_q <= raw_d;
`endif
      end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed vector table plus hand sequences for ignored start, output hold and async reset.
module tb_divider;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   divider_if #(.BITS(8)) bus();
   divider #(.BITS(8)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [7:0] a, b, q, r;
      logic       dz;
   } vec_t;
   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask
   task automatic start_op(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_dividend = a;
      bus.i_divisor = b;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_dividend = 8'($urandom);
      bus.i_divisor = 8'($urandom);
   endtask
   task automatic wait_done(input int start_n, input string tag);
      int n = start_n;
      while (!bus.o_finished && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " latency"}, n, 8);
      @(posedge clk);
      #1;
      check({tag, " pulse end"}, {30'd0, bus.o_finished, bus.o_busy}, 0);
   endtask
   initial begin
      vec_t vecs[$];
      logic bad;
`ifdef DIVIDER_SIGNED_EN
      vecs = '{'{8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0}, '{8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0},
               '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0}, '{8'h9C, 8'd3, 8'hDF, 8'hFF, 1'b0},
               '{8'd45, 8'd0, 8'hFF, 8'd45, 1'b1}, '{8'hF9, 8'd0, 8'hFF, 8'hF9, 1'b1},
               '{8'd5, 8'd9, 8'd0, 8'd5, 1'b0}};
`else
      vecs = '{'{8'd200, 8'd7, 8'd28, 8'd4, 1'b0}, '{8'd45, 8'd0, 8'd255, 8'd45, 1'b1},
               '{8'd5, 8'd9, 8'd0, 8'd5, 1'b0}, '{8'd255, 8'd1, 8'd255, 8'd0, 1'b0},
               '{8'd7, 8'd255, 8'd0, 8'd7, 1'b0}, '{8'd0, 8'd3, 8'd0, 8'd0, 1'b0}};
`endif
      bus.i_start = 1'b0;
      bus.i_dividend = '0;
      bus.i_divisor = '0;
      #12;
      check("reset outputs", {bus.o_quotient, bus.o_remainder, 13'd0, bus.o_div_by_zero,
            bus.o_busy, bus.o_finished}, 0);
      @(negedge clk);
      rst = 1'b0;
      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b);
         check($sformatf("v%0d busy", i), int'(bus.o_busy), 1);
         wait_done(0, $sformatf("v%0d", i));
         check($sformatf("v%0d quotient", i), int'(bus.o_quotient), int'(vecs[i].q));
         check($sformatf("v%0d remainder", i), int'(bus.o_remainder), int'(vecs[i].r));
         check($sformatf("v%0d dz", i), int'(bus.o_div_by_zero), int'(vecs[i].dz));
      end
      // a start pulse during iteration 3 must be ignored
      start_op(8'd100, 8'd3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_dividend = 8'd9;
      bus.i_divisor = 8'd2;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      wait_done(3, "ignored start");
      check("ignored quotient", int'(bus.o_quotient), 33);
      check("ignored remainder", int'(bus.o_remainder), 1);
      // results hold through the next start until its DONE
      start_op(8'd45, 8'd0);
      bad = 1'b0;
      for (int k = 1; k < 8; k++) begin
         if (bus.o_quotient != 8'd33 || bus.o_remainder != 8'd1 || bus.o_div_by_zero) bad = 1'b1;
         @(posedge clk);
         #1;
      end
      check("hold outputs", int'(bad), 0);
      wait_done(7, "hold op");
      check("hold op results", {bus.o_quotient, bus.o_remainder, 15'd0, bus.o_div_by_zero},
            {8'd255, 8'd45, 15'd0, 1'b1});
      // asynchronous reset mid-iteration
      start_op(8'd100, 8'd3);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async reset outputs", {bus.o_quotient, bus.o_remainder, 13'd0, bus.o_div_by_zero,
            bus.o_busy, bus.o_finished}, 0);
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.o_finished || bus.o_busy) bad = 1'b1;
      end
      check("no finish after reset", int'(bad), 0);
      start_op(8'd12, 8'd4);
      wait_done(0, "post reset");
      check("post reset quotient", int'(bus.o_quotient), 3);
      check("post reset remainder", int'(bus.o_remainder), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential restoring divider computing quotient = dividend / divisor and remainder = dividend % divisor.
- Inverse companion to the shift-and-add multiplier in the arithmetic unit.
- Uses the same start/finished control handshake, so the control sequencer drives both blocks identically.
- Retires one quotient bit per clock. One subtractor of BITS+1 bits; no combinational divide array.

Parameters:
- BITS, 8, operand width; dividend, divisor, quotient and remainder are all BITS wide (BITS >= 2).

Ports:
- i_clock  input  1  rising-edge clock
- i_reset  input  1  asynchronous, active-high reset
- i_start  input  1  request a division; sampled only in IDLE
- o_busy  output  1  high while a division is in progress (LOAD..DONE inclusive)
- o_finished  output  1  one-cycle pulse; results valid from this cycle
- i_dividend  input  BITS  dividend, sampled on the accepting edge
- i_divisor  input  BITS  divisor, sampled on the accepting edge
- o_quotient  output  BITS  registered quotient
- o_remainder  output  BITS  registered remainder
- o_div_by_zero  output  1  registered; high with results when the sampled divisor was 0

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE immediately.
  - o_busy, o_finished, o_quotient, o_remainder, o_div_by_zero all go to 0.
  - Reset mid-operation aborts the division with no partial results.
- States are IDLE, ITER, DONE. A bit counter counts 0..BITS-1.
- IDLE, start accepted (i_start=1 on edge E0):
  - Latch dividend into the quotient shift register, divisor into the divisor register, and clear the partial remainder (BITS+1 bits).
  - Clear the counter, capture divisor==0, and go to ITER.
- ITER, each edge:
  - R = {R[BITS-1:0], Q[BITS-1]}; Q = Q << 1.
  - If R >= divisor: R = R - divisor and Q[0] = 1. Otherwise Q[0] = 0.
  - After BITS edges (E1..E_BITS), write o_quotient and o_remainder and go to DONE.
- DONE, one cycle:
  - o_finished = 1, then go to IDLE on the next edge.
- Latency: o_finished is high in the cycle after edge E_BITS, i.e. exactly BITS clocks after the accepting edge.
- Throughput: the next start can be accepted BITS+2 clocks after the previous one.
- o_busy is high in ITER and DONE.
- i_start is ignored while o_busy=1. It is never queued.
- Input ports are don't-care after E0.
- Outputs hold their values from DONE until the next DONE or a reset. They do not clear at the next start.
- Divide by zero:
  - Not trapped. The division runs with full latency.
  - The algorithm naturally yields quotient = all ones and remainder = dividend; these are the required results.
  - o_div_by_zero = 1, updated at the same edge as the results.
- Invariants on completion: remainder < divisor whenever divisor != 0, and quotient*divisor + remainder == dividend (mod 2^BITS, unsigned).

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- With the macro defined:
  - Operands are two's complement.
  - At LOAD, magnitudes are taken and the operand signs are stored.
  - At result write: quotient is negated if the signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Latency is unchanged.
  - Overflow case: -2^(BITS-1) / -1 gives quotient = -2^(BITS-1) (wraps), remainder 0, no flag.
  - Divide by zero still forces quotient = all ones and remainder = raw dividend.
- Without the macro: purely unsigned; no sign logic is synthesized.

Test Plan (BITS=8):
- 200/7 -> quotient 28, remainder 4, o_div_by_zero 0; o_finished high exactly 8 clocks after the accepting edge, for one cycle.
- 45/0 -> quotient 255, remainder 45, o_div_by_zero 1, same latency. Then 5/9 -> quotient 0, remainder 5, flag cleared.
- 255/1 -> quotient 255, remainder 0. Then 7/255 -> quotient 0, remainder 7.
- Start 100/3; pulse i_start with 9/2 at iteration 3 -> ignored; result 33 r 1. Outputs hold 33/1 through the next start until its DONE.
- Start 100/3; assert i_reset asynchronously at iteration 4 -> all outputs 0 immediately; no o_finished. After release, 12/4 -> quotient 3, remainder 0.
- DIVIDER_SIGNED_EN:
  - -7/2 -> quotient 0xFD (-3), remainder 0xFF (-1).
  - 7/-2 -> quotient 0xFD, remainder 0x01.
  - -128/-1 -> quotient 0x80, remainder 0.
